// File: rtl/xor_stream_decryptor_pkg.sv
// Shared definitions for the XOR stream cipher blocks: LFSR width, default
// polynomial and zero-seed substitute, frame state encoding, and the Galois step.
package xor_stream_decryptor_pkg;

  localparam int LFSR_W = 16;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [LFSR_W-1:0] DEF_LFSR_TAPS     = 16'hB400;
  // An all-zero LFSR never leaves zero, so a zero seed is swapped for this one
  localparam logic [LFSR_W-1:0] DEF_SEED_ZERO_SUB = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One right-shifting Galois step: shift, then fold the polynomial in when bit 0 was set
  function automatic logic [LFSR_W-1:0] galois_step(input logic [LFSR_W-1:0] cur,
                                                    input logic [LFSR_W-1:0] taps);
    return (cur >> 1) ^ (cur[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/xor_stream_decryptor_keystream_lfsr.sv
// Keystream generator shared by the encrypting and decrypting ends of the
// cipher. load takes priority over advance; a zero seed is substituted.
module keystream_lfsr
  import xor_stream_decryptor_pkg::*;
#(
  parameter logic [LFSR_W-1:0] TAPS     = DEF_LFSR_TAPS,
  parameter logic [LFSR_W-1:0] ZERO_SUB = DEF_SEED_ZERO_SUB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  // LFSR register: reload on frame start, one Galois step per consumed byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ZERO_SUB;
    end else if (load) begin
      state <= (seed == '0) ? ZERO_SUB : seed;
    end else if (advance) begin
      state <= galois_step(state, TAPS);
    end
  end

endmodule

// File: rtl/xor_stream_decryptor.sv
// Decrypting end of the XOR stream cipher. A frame of frame_len bytes is
// XORed with the LFSR keystream and presented through one registered output
// stage.
//
// Handshake: on both streams a byte moves on a rising edge where valid and
// ready are both high. A producer holds valid and data stable until that edge,
// and valid never depends on ready. c_ready is combinational from registered
// state and p_ready, so a byte can be taken and a new byte accepted in the
// same cycle.
module xor_stream_decryptor
  import xor_stream_decryptor_pkg::*;
#(
  parameter int                DATA_W        = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS     = DEF_LFSR_TAPS,
  parameter logic [LFSR_W-1:0] SEED_ZERO_SUB = DEF_SEED_ZERO_SUB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       seed,
  input  logic [15:0]       frame_len,
  input  logic              c_valid,
  output logic              c_ready,
  input  logic [DATA_W-1:0] c_data,
  output logic              p_valid,
  input  logic              p_ready,
  output logic [DATA_W-1:0] p_data,
  output logic              p_last,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  state_t            state;
  // 17 bits so that a frame_len of 0 can stand for 65536 bytes
  logic [16:0]       count;
  logic [LFSR_W-1:0] ks_state;
  logic              accept;
  logic              take;
  logic              start_ok;

  assign start_ok  = start && (state == IDLE);
  assign c_ready   = (state == RUN) && (!p_valid || p_ready);
  assign accept    = c_valid && c_ready;
  assign take      = p_valid && p_ready;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  keystream_lfsr #(
    .TAPS     (LFSR_TAPS),
    .ZERO_SUB (SEED_ZERO_SUB)
  ) u_keystream (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start_ok),
    .seed    (seed),
    .advance (accept),
    .state   (ks_state)
  );

  // Frame control: track remaining bytes and walk IDLE -> RUN -> DRAIN -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            count <= (frame_len == 16'd0) ? 17'h10000 : {1'b0, frame_len};
          end
        end
        RUN: begin
          if (accept) begin
            count <= count - 17'd1;
            if (count == 17'd1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (take) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output stage: load on accept, otherwise drop valid once the byte is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_data  <= '0;
      p_last  <= 1'b0;
    end else if (accept) begin
      p_valid <= 1'b1;
      p_data  <= c_data ^ ks_state[DATA_W-1:0];
      p_last  <= (count == 17'd1);
    end else if (take) begin
      p_valid <= 1'b0;
      p_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_stream_decryptor.sv
// Bench for xor_stream_decryptor: directed frames plus random round-trip
// frames, with a transaction-level model of the expected output stream.
module tb_xor_stream_decryptor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] seed;
  logic [15:0] frame_len;
  logic        c_valid;
  logic        c_ready;
  logic [7:0]  c_data;
  logic        p_valid;
  logic        p_ready;
  logic [7:0]  p_data;
  logic        p_last;
  logic        busy;
  logic [1:0]  dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // ciphertext to feed, and the plaintext expected back, for the current frame
  logic [7:0] cip_q[$];
  logic [7:0] exp_q[$];

  xor_stream_decryptor #(
    .DATA_W        (8),
    .LFSR_TAPS     (16'hB400),
    .SEED_ZERO_SUB (16'hACE1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed),
    .frame_len (frame_len),
    .c_valid   (c_valid),
    .c_ready   (c_ready),
    .c_data    (c_data),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .p_data    (p_data),
    .p_last    (p_last),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Encrypt a random plaintext frame with the reference keystream
  task automatic make_frame(input logic [15:0] sd, input int len);
    logic [15:0] ks;
    logic [7:0]  p;
    ks = (sd == 16'h0000) ? 16'hACE1 : sd;
    cip_q.delete();
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      p = 8'($urandom);
      exp_q.push_back(p);
      cip_q.push_back(p ^ ks[7:0]);
      ks = lfsr_next(ks);
    end
  endtask

  // Start a frame and stream cip_q through, checking every output cycle
  task automatic run_frame(input logic [15:0] sd, input int len, input int vld_pct,
                           input int rdy_pct, input int hold, input bit spam,
                           output int cycles);
    int         sent;
    int         got;
    int         budget;
    bit         pending;
    bit         running;
    bit         acc;
    bit         tk;
    logic [7:0] pend_data;
    bit         pend_last;
    sent = 0; got = 0; cycles = 0; pending = 0; pend_data = '0; pend_last = 0;
    budget = len * 30 + 50;
    @(posedge clk); #1;
    start = 1'b1; seed = sd; frame_len = len[15:0]; c_valid = 1'b0; p_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; seed = 16'($urandom); frame_len = 16'($urandom);
    running = 1;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    while (got < len && cycles < budget) begin
      c_valid = (sent < len) && ($urandom_range(0, 99) < vld_pct);
      c_data  = c_valid ? cip_q[sent] : 8'($urandom);
      if (hold > 0 && pending) begin
        p_ready = 1'b0;
        hold--;
      end else begin
        p_ready = ($urandom_range(0, 99) < rdy_pct);
      end
      if (spam) begin
        start = 1'($urandom_range(0, 1));
        seed  = 16'($urandom);
        frame_len = 16'($urandom);
      end
      @(negedge clk);
      check("c_ready", {31'd0, c_ready}, {31'd0, running && (!pending || p_ready)});
      check("p_valid", {31'd0, p_valid}, {31'd0, pending});
      check("busy", {31'd0, busy}, {31'd0, running || pending});
      if (pending) begin
        check("p_data", {24'd0, p_data}, {24'd0, pend_data});
        check("p_last", {31'd0, p_last}, {31'd0, pend_last});
      end
      tk  = pending && p_ready;
      acc = running && c_valid && (!pending || p_ready);
      if (tk) begin
        got++;
        pending = 0;
      end
      if (acc) begin
        pending   = 1;
        pend_data = exp_q[sent];
        pend_last = (sent == len - 1);
        sent++;
        running   = (sent < len);
      end
      cycles++;
      @(posedge clk); #1;
    end
    start = 1'b0; c_valid = 1'b0; p_ready = 1'b0;
    check("frame_done_in_budget", {31'd0, (got == len)}, 32'd1);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    check("p_valid_after_frame", {31'd0, p_valid}, 32'd0);
  endtask

  int         cyc;
  logic [15:0] rs;

  initial begin
    rst_n = 1'b0; start = 1'b0; seed = '0; frame_len = '0;
    c_valid = 1'b0; c_data = '0; p_ready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_p_valid", {31'd0, p_valid}, 32'd0);
    check("rst_p_data",  {24'd0, p_data}, 32'd0);
    check("rst_p_last",  {31'd0, p_last}, 32'd0);
    check("rst_c_ready", {31'd0, c_ready}, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_state",   {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ciphertext offered while idle is refused
    c_valid = 1'b1; c_data = 8'h5A; p_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_c_ready", {31'd0, c_ready}, 32'd0);
      check("idle_p_valid", {31'd0, p_valid}, 32'd0);
    end
    c_valid = 1'b0;

    // known-answer frame: seed ACE1, two bytes decrypt to zero
    cip_q = '{8'hE1, 8'h70};
    exp_q = '{8'h00, 8'h00};
    run_frame(16'hACE1, 2, 100, 100, 0, 0, cyc);

    // zero seed is substituted with ACE1
    cip_q = '{8'hE1};
    exp_q = '{8'h00};
    run_frame(16'h0000, 1, 100, 100, 0, 0, cyc);

    // full throughput: 4 bytes leave on 4 consecutive cycles
    make_frame(16'h1234, 4);
    run_frame(16'h1234, 4, 100, 100, 0, 0, cyc);
    check("throughput_cycles", cyc, 32'd5);

    // consumer stalls 5 cycles with input pending
    make_frame(16'hBEEF, 3);
    run_frame(16'hBEEF, 3, 100, 100, 5, 0, cyc);

    // random short frames under random backpressure
    for (int i = 0; i < 4; i++) begin
      rs = 16'($urandom);
      make_frame(rs, $urandom_range(1, 20));
      run_frame(rs, exp_q.size(), $urandom_range(30, 100), $urandom_range(30, 100), 0, 0, cyc);
    end

    // reset in the middle of a frame
    make_frame(16'hACE1, 4);
    @(posedge clk); #1;
    start = 1'b1; seed = 16'hACE1; frame_len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0; c_valid = 1'b1; c_data = cip_q[0]; p_ready = 1'b1;
    @(posedge clk); #1;
    c_data = cip_q[1];
    @(posedge clk); #1;
    c_valid = 1'b0; p_ready = 1'b0;
    #1;
    check("mid_p_valid", {31'd0, p_valid}, 32'd1);
    check("mid_p_data",  {24'd0, p_data}, {24'd0, exp_q[1]});
    rst_n = 1'b0;
    #1;
    check("async_rst_p_valid", {31'd0, p_valid}, 32'd0);
    check("async_rst_p_data",  {24'd0, p_data}, 32'd0);
    check("async_rst_busy",    {31'd0, busy}, 32'd0);
    check("async_rst_c_ready", {31'd0, c_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; c_valid = 1'b1; c_data = 8'($urandom); p_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_p_valid", {31'd0, p_valid}, 32'd0);
      check("post_rst_c_ready", {31'd0, c_ready}, 32'd0);
    end
    c_valid = 1'b0;
    cip_q = '{8'hE1, 8'h70};
    exp_q = '{8'h00, 8'h00};
    run_frame(16'hACE1, 2, 100, 100, 0, 0, cyc);

    // round trip of 256 random bytes with stray start pulses during the frame
    rs = 16'($urandom);
    make_frame(rs, 256);
    run_frame(rs, 256, 75, 75, 0, 1, cyc);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
